// File: rtl/layer_cfg_sequencer.sv
// layer_cfg_sequencer: holds a host-written table of per-layer configuration
// words. On a layer start request it streams that layer's words to the chip,
// then issues a one-cycle start_layer pulse. A per-word stall timeout and
// sticky error flags guard the transfer.
//
// Handshake (cfg_valid/cfg_ready): a word transfers on a rising edge where
// cfg_valid && cfg_ready. While cfg_valid is high and the word has not
// transferred, cfg_addr and cfg_data are held stable. cfg_valid never depends
// combinationally on cfg_ready. The only way valid drops without a transfer
// is a stall timeout.
module layer_cfg_sequencer #(
  parameter int MAX_LAYERS  = 64,
  parameter int CFG_WORDS   = 4,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 1024,
  localparam int WW         = $clog2(CFG_WORDS)
) (
  input  logic              chip_clk,
  input  logic              rstn,
  input  logic              host_wr_en,
  input  logic [5:0]        host_wr_layer,
  input  logic [WW-1:0]     host_wr_word,
  input  logic [DATA_W-1:0] host_wr_data,
  input  logic              cfg_bypass,
  input  logic              clear_err,
  input  logic              start_req,
  input  logic [5:0]        layer_idx,
  output logic              busy,
  output logic              cfg_valid,
  output logic [WW-1:0]     cfg_addr,
  output logic [DATA_W-1:0] cfg_data,
  input  logic              cfg_ready,
  output logic              start_layer,
  output logic [31:0]       cfg_word_cnt,
  output logic              err_timeout,
  output logic              err_overrun,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SEND  = 2'd2,
    S_START = 2'd3
  } state_t;

  localparam int SW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [SW-1:0] TO_LAST  = (TIMEOUT_CYC == 0) ? '0 : SW'(TIMEOUT_CYC - 1);
  localparam logic [WW-1:0] LAST_W   = WW'(CFG_WORDS - 1);
  localparam logic [6:0]    LAYERS_7 = 7'(MAX_LAYERS);

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   cfg_tbl [MAX_LAYERS*CFG_WORDS];
  logic [5:0]          lay_q;
  logic                skip_q;
  logic [WW-1:0]       word_q;
  logic [SW-1:0]       stall_q;
  logic                do_start, do_load, do_accept, do_abort, stall_hit, overrun;

  assign busy        = (state_q != S_IDLE);
  assign cfg_valid   = (state_q == S_SEND);
  assign start_layer = (state_q == S_START);
  assign dbg_state   = state_q;

  assign stall_hit = (TIMEOUT_CYC != 0) && !cfg_ready && (stall_q == TO_LAST);
  assign overrun   = start_req && (state_q != S_IDLE);

  // Host table writes, accepted in any state; out-of-range layers are dropped.
  always_ff @(posedge chip_clk) begin
    if (host_wr_en && ({1'b0, host_wr_layer} < LAYERS_7))
      cfg_tbl[{host_wr_layer, host_wr_word}] <= host_wr_data;
  end

  // State register.
  always_ff @(posedge chip_clk or negedge rstn) begin
    if (!rstn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state and datapath strobes. The bypass decision resolves in the
  // load stage so a bypassed start pulses two cycles after the request.
  always_comb begin
    state_d   = state_q;
    do_start  = 1'b0;
    do_load   = 1'b0;
    do_accept = 1'b0;
    do_abort  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_req) begin
          do_start = 1'b1;
          state_d  = S_LOAD;
        end
      end
      S_LOAD: begin
        if (skip_q) begin
          state_d = S_START;
        end else begin
          do_load = 1'b1;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (cfg_ready) begin
          do_accept = 1'b1;
          state_d   = (word_q == LAST_W) ? S_START : S_LOAD;
        end else if (stall_hit) begin
          do_abort = 1'b1;
          state_d  = S_IDLE;
        end
      end
      S_START: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Sequence datapath: latched layer, word index, output word and stall count.
  always_ff @(posedge chip_clk or negedge rstn) begin
    if (!rstn) begin
      lay_q        <= '0;
      skip_q       <= 1'b0;
      word_q       <= '0;
      stall_q      <= '0;
      cfg_addr     <= '0;
      cfg_data     <= '0;
      cfg_word_cnt <= '0;
    end else begin
      if (do_start) begin
        lay_q  <= layer_idx;
        skip_q <= cfg_bypass || ({1'b0, layer_idx} >= LAYERS_7);
        word_q <= '0;
      end
      if (do_load) begin
        cfg_data <= cfg_tbl[{lay_q, word_q}];
        cfg_addr <= word_q;
        stall_q  <= '0;
      end else if (cfg_valid && !cfg_ready) begin
        stall_q <= stall_q + SW'(1);
      end
      if (do_accept) begin
        cfg_word_cnt <= cfg_word_cnt + 32'd1;
        if (word_q != LAST_W) word_q <= word_q + WW'(1);
      end
    end
  end

  // Sticky error flags; a new error event wins over a same-cycle clear.
  always_ff @(posedge chip_clk or negedge rstn) begin
    if (!rstn) begin
      err_timeout <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      if (clear_err) begin
        err_timeout <= 1'b0;
        err_overrun <= 1'b0;
      end
      if (do_abort) err_timeout <= 1'b1;
      if (overrun)  err_overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_layer_cfg_sequencer.sv
// Directed bench for layer_cfg_sequencer: table load, normal transfer,
// back-pressure, timeout, bypass, overrun, live table write and mid-run reset.
module tb_layer_cfg_sequencer;

  localparam int DATA_W = 32;

  logic              chip_clk;
  logic              rstn;
  logic              host_wr_en;
  logic [5:0]        host_wr_layer;
  logic [1:0]        host_wr_word;
  logic [DATA_W-1:0] host_wr_data;
  logic              cfg_bypass;
  logic              clear_err;
  logic              start_req;
  logic [5:0]        layer_idx;
  logic              busy;
  logic              cfg_valid;
  logic [1:0]        cfg_addr;
  logic [DATA_W-1:0] cfg_data;
  logic              cfg_ready;
  logic              start_layer;
  logic [31:0]       cfg_word_cnt;
  logic              err_timeout;
  logic              err_overrun;
  logic [1:0]        dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [DATA_W-1:0] exp_q[$];

  layer_cfg_sequencer #(
    .MAX_LAYERS (64),
    .CFG_WORDS  (4),
    .DATA_W     (DATA_W),
    .TIMEOUT_CYC(8)
  ) dut (
    .chip_clk     (chip_clk),
    .rstn         (rstn),
    .host_wr_en   (host_wr_en),
    .host_wr_layer(host_wr_layer),
    .host_wr_word (host_wr_word),
    .host_wr_data (host_wr_data),
    .cfg_bypass   (cfg_bypass),
    .clear_err    (clear_err),
    .start_req    (start_req),
    .layer_idx    (layer_idx),
    .busy         (busy),
    .cfg_valid    (cfg_valid),
    .cfg_addr     (cfg_addr),
    .cfg_data     (cfg_data),
    .cfg_ready    (cfg_ready),
    .start_layer  (start_layer),
    .cfg_word_cnt (cfg_word_cnt),
    .err_timeout  (err_timeout),
    .err_overrun  (err_overrun),
    .dbg_state    (dbg_state)
  );

  // Clock
  initial chip_clk = 1'b0;
  always #5 chip_clk = ~chip_clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic host_write(input logic [5:0] lay, input logic [1:0] w, input logic [31:0] d);
    @(posedge chip_clk); #1;
    host_wr_en = 1'b1; host_wr_layer = lay; host_wr_word = w; host_wr_data = d;
    @(posedge chip_clk); #1;
    host_wr_en = 1'b0;
  endtask

  task automatic pulse_clear;
    @(posedge chip_clk); #1; clear_err = 1'b1;
    @(posedge chip_clk); #1; clear_err = 1'b0;
  endtask

  // Runs one sequence for ncyc cycles; cycle 0 carries start_req.
  // cfg_ready is low over [lo_from, lo_to]; ov_c issues a second start_req
  // together with clear_err; wr_c writes word wr_w of the active layer.
  task automatic run_seq(input logic [5:0] lay, input logic byp,
                         input int lo_from, input int lo_to, input int ov_c,
                         input int wr_c, input logic [1:0] wr_w, input logic [31:0] wr_d,
                         input int ncyc,
                         output int first_v, output int n_vld, output int busy_off,
                         output int pulse_c, output int n_pulse, output int n_hs);
    logic [31:0] held_d;
    logic [1:0]  held_a;
    logic        stalled;
    first_v = -1; n_vld = 0; busy_off = -1; pulse_c = -1; n_pulse = 0; n_hs = 0;
    stalled = 1'b0; held_d = '0; held_a = '0;
    for (int c = 0; c < ncyc; c++) begin
      @(posedge chip_clk); #1;
      start_req     = (c == 0) || (c == ov_c);
      clear_err     = (c == ov_c);
      layer_idx     = (c == 0) ? lay : ~lay;
      cfg_bypass    = byp;
      cfg_ready     = !(c >= lo_from && c <= lo_to);
      host_wr_en    = (c == wr_c);
      host_wr_layer = lay;
      host_wr_word  = wr_w;
      host_wr_data  = wr_d;
      @(negedge chip_clk);
      if (c == 1) check_eq("busy_c1", {31'd0, busy}, 32'd1);
      if (c >= 1 && !busy && busy_off < 0) busy_off = c;
      if (cfg_valid) begin
        n_vld++;
        if (first_v < 0) first_v = c;
        if (stalled) begin
          check_eq("hold_data", cfg_data, held_d);
          check_eq("hold_addr", {30'd0, cfg_addr}, {30'd0, held_a});
        end
      end
      stalled = cfg_valid && !cfg_ready;
      held_d  = cfg_data;
      held_a  = cfg_addr;
      if (cfg_valid && cfg_ready) begin
        check_eq("hs_addr", {30'd0, cfg_addr}, n_hs);
        if (exp_q.size() == 0) check_eq("hs_extra", 32'd1, 32'd0);
        else check_eq("hs_data", cfg_data, exp_q.pop_front());
        n_hs++;
      end
      if (start_layer) begin
        n_pulse++;
        if (pulse_c < 0) pulse_c = c;
      end
    end
    @(posedge chip_clk); #1;
    start_req = 1'b0; clear_err = 1'b0; host_wr_en = 1'b0; cfg_bypass = 1'b0; cfg_ready = 1'b0;
    exp_q.delete();
  endtask

  int fv, nv, bo, pc, np, nh;
  int seen_pulse;

  initial begin
    rstn = 1'b0; host_wr_en = 1'b0; host_wr_layer = '0; host_wr_word = '0; host_wr_data = '0;
    cfg_bypass = 1'b0; clear_err = 1'b0; start_req = 1'b0; layer_idx = '0; cfg_ready = 1'b0;
    repeat (3) @(posedge chip_clk);
    @(negedge chip_clk);
    check_eq("rst_busy",  {31'd0, busy}, 32'd0);
    check_eq("rst_valid", {31'd0, cfg_valid}, 32'd0);
    check_eq("rst_start", {31'd0, start_layer}, 32'd0);
    check_eq("rst_addr",  {30'd0, cfg_addr}, 32'd0);
    check_eq("rst_data",  cfg_data, 32'd0);
    check_eq("rst_cnt",   cfg_word_cnt, 32'd0);
    check_eq("rst_errs",  {30'd0, err_timeout, err_overrun}, 32'd0);
    check_eq("rst_state", {30'd0, dbg_state}, 32'd0);
    @(posedge chip_clk); #1; rstn = 1'b1;

    for (int w = 0; w < 4; w++) begin
      host_write(6'd3, 2'(w), 32'hA000_0000 + w);
      host_write(6'd5, 2'(w), 32'hB5B5_0000 + w);
    end

    // Normal transfer, ready always high.
    for (int w = 0; w < 4; w++) exp_q.push_back(32'hA000_0000 + w);
    run_seq(6'd3, 1'b0, -1, -2, -1, -1, 2'd0, 32'd0, 20, fv, nv, bo, pc, np, nh);
    check_eq("t1_first_valid", fv, 2);
    check_eq("t1_vld_cycles", nv, 4);
    check_eq("t1_pulse", pc, 9);
    check_eq("t1_npulse", np, 1);
    check_eq("t1_busy_off", bo, 10);
    check_eq("t1_hs", nh, 4);
    check_eq("t1_cnt", cfg_word_cnt, 32'd4);

    // Word 2 stalled for 5 cycles.
    for (int w = 0; w < 4; w++) exp_q.push_back(32'hA000_0000 + w);
    run_seq(6'd3, 1'b0, 6, 10, -1, -1, 2'd0, 32'd0, 20, fv, nv, bo, pc, np, nh);
    check_eq("t2_vld_cycles", nv, 9);
    check_eq("t2_pulse", pc, 14);
    check_eq("t2_busy_off", bo, 15);
    check_eq("t2_hs", nh, 4);
    check_eq("t2_cnt", cfg_word_cnt, 32'd8);
    check_eq("t2_err_to", {31'd0, err_timeout}, 32'd0);

    // Ready stuck low: timeout after 8 stall cycles.
    run_seq(6'd3, 1'b0, 0, 1000, -1, -1, 2'd0, 32'd0, 16, fv, nv, bo, pc, np, nh);
    check_eq("t3_first_valid", fv, 2);
    check_eq("t3_vld_cycles", nv, 8);
    check_eq("t3_busy_off", bo, 10);
    check_eq("t3_npulse", np, 0);
    check_eq("t3_hs", nh, 0);
    check_eq("t3_err_to", {31'd0, err_timeout}, 32'd1);
    check_eq("t3_cnt", cfg_word_cnt, 32'd8);
    pulse_clear();
    @(negedge chip_clk);
    check_eq("t3_err_clr", {31'd0, err_timeout}, 32'd0);

    // Bypass.
    run_seq(6'd5, 1'b1, -1, -2, -1, -1, 2'd0, 32'd0, 10, fv, nv, bo, pc, np, nh);
    check_eq("t4_pulse", pc, 2);
    check_eq("t4_npulse", np, 1);
    check_eq("t4_busy_off", bo, 3);
    check_eq("t4_vld_cycles", nv, 0);
    check_eq("t4_cnt", cfg_word_cnt, 32'd8);

    // Second start_req while busy, with a same-cycle clear_err.
    for (int w = 0; w < 4; w++) exp_q.push_back(32'hB5B5_0000 + w);
    run_seq(6'd5, 1'b0, -1, -2, 3, -1, 2'd0, 32'd0, 20, fv, nv, bo, pc, np, nh);
    check_eq("t5_pulse", pc, 9);
    check_eq("t5_npulse", np, 1);
    check_eq("t5_hs", nh, 4);
    check_eq("t5_err_ov", {31'd0, err_overrun}, 32'd1);
    check_eq("t5_cnt", cfg_word_cnt, 32'd12);
    pulse_clear();
    @(negedge chip_clk);
    check_eq("t5_err_clr", {31'd0, err_overrun}, 32'd0);

    // Host rewrites word 3 of the active layer while word 1 stalls.
    exp_q.push_back(32'hA000_0000);
    exp_q.push_back(32'hA000_0001);
    exp_q.push_back(32'hA000_0002);
    exp_q.push_back(32'hDEAD_BEE3);
    run_seq(6'd3, 1'b0, 4, 8, -1, 5, 2'd3, 32'hDEAD_BEE3, 20, fv, nv, bo, pc, np, nh);
    check_eq("t6_pulse", pc, 14);
    check_eq("t6_hs", nh, 4);
    check_eq("t6_cnt", cfg_word_cnt, 32'd16);

    // Asynchronous reset in the middle of a stalled word.
    @(posedge chip_clk); #1; start_req = 1'b1; layer_idx = 6'd3; cfg_ready = 1'b0;
    @(posedge chip_clk); #1; start_req = 1'b0;
    repeat (2) @(posedge chip_clk);
    #3;
    check_eq("t7_pre_valid", {31'd0, cfg_valid}, 32'd1);
    rstn = 1'b0;
    #1;
    check_eq("t7_rst_flags", {27'd0, busy, cfg_valid, start_layer, err_timeout, err_overrun}, 32'd0);
    check_eq("t7_rst_data", cfg_data, 32'd0);
    check_eq("t7_rst_addr", {30'd0, cfg_addr}, 32'd0);
    check_eq("t7_rst_cnt", cfg_word_cnt, 32'd0);
    @(posedge chip_clk); #1; rstn = 1'b1; cfg_ready = 1'b1;
    seen_pulse = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge chip_clk);
      if (start_layer || busy) seen_pulse++;
    end
    check_eq("t7_no_start", seen_pulse, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
